execute_hazard_controller: RTL and testbench
============================================

Name: execute_hazard_controller

Overview:
- Sequences the execute stage of the 16-bit pipeline by issuing the registered ID→EX control for each instruction: ALU operand mux selects, regwrite, rd and valid.
- Detects distance-1 RAW hazards and steers the operand muxes to the forwarded ALU result.
- Stalls decode on load-use hazards.
- Runs a flush FSM that squashes wrong-path instructions after a taken branch resolves in execute.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush is held after a taken branch (1..7).
- REG_AW, 4, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1  in  REG_AW  source register A index
- id_rs2  in  REG_AW  source register B index
- id_rs1_used  in  1  operand A reads id_rs1
- id_rs2_used  in  1  operand B reads id_rs2
- id_src1  in  2  base select for operand 1 (0=pc, 1=a)
- id_src2  in  2  base select for operand 2 (0=b, 1=const 2, 2=imm)
- id_rd  in  REG_AW  destination register
- id_regwrite  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load (result not available from ALU)
- ex_branch  in  1  instruction now in EX is a conditional branch
- ex_cond  in  2  branch condition (0=zero, 1=!zero, 2=pos, 3=always)
- ex_zero  in  1  ALU zero flag
- ex_pos  in  1  ALU pos flag
- aluin1  out  2  registered operand 1 select (2=forwarded_aluout)
- aluin2  out  2  registered operand 2 select (3=forwarded_aluout)
- ex_rd  out  REG_AW  registered rd to execute
- ex_regwrite  out  1  registered regwrite to execute
- ex_valid  out  1  execute slot holds a real instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- flush  out  1  squash IF/ID; registered FSM output
- pc_redirect  out  1  one-cycle pulse: taken branch, load branch target

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - aluin1=0, aluin2=0, ex_rd=0, ex_regwrite=0, ex_valid=0, flush=0, pc_redirect=0.
  - Internal ex_is_load=0; FSM=RUN; flush counter=0.
  - Reset wins over every other event, including mid-FLUSH.
- Internal EX tracking register: ex_is_load, loaded alongside ex_rd/ex_regwrite/ex_valid.
- Hazard match (combinational):
  - hazA = id_valid & id_rs1_used & ex_valid & ex_regwrite & (ex_rd!=0) & (ex_rd==id_rs1); hazB is the same using id_rs2.
  - r0 never matches.
  - Distance ≥2 needs no action; the register file is write-through.
- Load-use: stall = (hazA|hazB) & ex_is_load & state==RUN & !taken.
- taken = ex_valid & ex_branch & cond_true, where cond_true per ex_cond: zero, !zero, pos, 1.
- Issue at each clk, in priority order:
  - (a) taken or state==FLUSH → insert bubble: ex_valid=0, ex_regwrite=0, ex_rd=0, selects 0, ex_is_load=0.
  - (b) stall → insert bubble (same values).
  - (c) otherwise → pass ID fields. aluin1 = hazA&!ex_is_load ? 2 : id_src1. aluin2 = hazB&!ex_is_load ? 3 : id_src2.
- Issue latency: 1 cycle from ID inputs to EX outputs.
- Load-use stall lasts exactly 1 cycle. The next cycle sees a bubble in EX, so no hazard remains.
- FSM:
  - RUN: on taken → pc_redirect=1 next cycle, flush=1, counter=FLUSH_CYCLES-1, go to FLUSH.
  - FLUSH: flush=1. Counter decrements; at 0 → RUN, flush=0.
  - A branch arriving in EX during FLUSH is already a bubble (ex_valid=0) and is ignored.
- Simultaneous taken and load-use: flush wins, stall=0.
- Bubble in ID (id_valid=0): no hazard, issues as a bubble with ex_valid=0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_count[15:0] and flush_count[15:0]:
  - Each increments once per cycle with stall or flush asserted.
  - Each saturates at 16'hFFFF and clears on rst.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - select constants: SEL1_PC=0, SEL1_A=1, SEL1_FWD=2, SEL2_B=0, SEL2_TWO=1, SEL2_IMM=2, SEL2_FWD=3.
  - branch condition encodings: COND_Z, COND_NZ, COND_POS, COND_ALWAYS.
  - FSM state type: RUN, FLUSH.
- One sub-module: branch_resolve, combinational: ex_cond/zero/pos → cond_true.

Test Plan:
- add r3 then add r4,r3,r5 (back-to-back): second issue has aluin1=2; no stall, no flush.
- load r3 then add r4,r5,r3: stall=1 for exactly 1 cycle; a bubble issues (ex_valid=0); the add then issues with aluin2=0, not 3.
- Taken branch (ex_cond=0, ex_zero=1) with FLUSH_CYCLES=2:
  - pc_redirect pulses for 1 cycle; flush is high for 2 cycles.
  - The 2 following ID instructions issue with ex_valid=0.
  - Untaken branch (ex_zero=0): no flush.
- Load in EX with a dependent ID instruction, and a simultaneous taken branch in EX: stall=0, flush=1, a bubble issues.
- Writer with rd=0 followed by a reader of r0: no forward (aluin1 = id_src1).
- Assert rst during the 2nd FLUSH cycle: next cycle flush=0, state RUN, all outputs at reset values. With HAZARD_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/execute_hazard_controller_pkg.sv
// Shared encodings for the execute hazard controller: operand mux selects,
// branch condition codes and the flush FSM state type.
package execute_hazard_controller_pkg;

    localparam logic [1:0] SEL1_PC  = 2'd0;
    localparam logic [1:0] SEL1_A   = 2'd1;
    localparam logic [1:0] SEL1_FWD = 2'd2;

    localparam logic [1:0] SEL2_B   = 2'd0;
    localparam logic [1:0] SEL2_TWO = 2'd1;
    localparam logic [1:0] SEL2_IMM = 2'd2;
    localparam logic [1:0] SEL2_FWD = 2'd3;

    localparam logic [1:0] COND_Z      = 2'd0;
    localparam logic [1:0] COND_NZ     = 2'd1;
    localparam logic [1:0] COND_POS    = 2'd2;
    localparam logic [1:0] COND_ALWAYS = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/execute_hazard_controller_branch_resolve.sv
// Branch condition evaluation for the instruction sitting in execute.
module execute_hazard_controller_branch_resolve
    import execute_hazard_controller_pkg::*;
(
    input  logic [1:0] ex_cond,
    input  logic       ex_zero,
    input  logic       ex_pos,
    output logic       cond_true
);

    // Map the condition code onto the ALU flags
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            COND_Z:      cond_true = ex_zero;
            COND_NZ:     cond_true = !ex_zero;
            COND_POS:    cond_true = ex_pos;
            COND_ALWAYS: cond_true = 1'b1;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_hazard_controller.sv
// ID->EX issue register with distance-1 forwarding, load-use stall and a
// post-branch flush FSM. Optional stall/flush event counters are built when
// HAZARD_STATS_EN is defined.
module execute_hazard_controller
    import execute_hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_AW       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [1:0]        id_src1,
    input  logic [1:0]        id_src2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              ex_branch,
    input  logic [1:0]        ex_cond,
    input  logic              ex_zero,
    input  logic              ex_pos,
    output logic [1:0]        aluin1,
    output logic [1:0]        aluin2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_valid,
    output logic              stall,
    output logic              flush,
    output logic              pc_redirect
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stall_count,
    output logic [15:0]       flush_count
`endif
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    logic [1:0]        aluin1_q, aluin1_d, aluin2_q, aluin2_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_valid_q, ex_valid_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic              pc_redirect_q, pc_redirect_d;
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;

    logic cond_true, taken, haz_a, haz_b, stall_c, flush_c;

    execute_hazard_controller_branch_resolve u_branch_resolve (
        .ex_cond   (ex_cond),
        .ex_zero   (ex_zero),
        .ex_pos    (ex_pos),
        .cond_true (cond_true)
    );

    // Hazard detection against the instruction in EX; r0 is never a producer
    always_comb begin
        taken   = ex_valid_q & ex_branch & cond_true;
        flush_c = (state_q == FLUSH);
        haz_a   = id_valid & id_rs1_used & ex_valid_q & ex_regwrite_q &
                  (ex_rd_q != '0) & (ex_rd_q == id_rs1);
        haz_b   = id_valid & id_rs2_used & ex_valid_q & ex_regwrite_q &
                  (ex_rd_q != '0) & (ex_rd_q == id_rs2);
        // A taken branch squashes the consumer anyway, so never stall then
        stall_c = (haz_a | haz_b) & ex_is_load_q & !flush_c & !taken;
    end

    // Next EX contents: bubble on flush/taken/stall/empty slot, else pass ID
    always_comb begin
        aluin1_d      = SEL1_PC;
        aluin2_d      = SEL2_B;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_valid_d    = 1'b0;
        ex_is_load_d  = 1'b0;
        if (!taken && !flush_c && !stall_c && id_valid) begin
            aluin1_d      = (haz_a && !ex_is_load_q) ? SEL1_FWD : id_src1;
            aluin2_d      = (haz_b && !ex_is_load_q) ? SEL2_FWD : id_src2;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_valid_d    = 1'b1;
            ex_is_load_d  = id_is_load;
        end
    end

    // Flush FSM: a taken branch opens a FLUSH window of FLUSH_CYCLES cycles
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_redirect_d = 1'b0;
        case (state_q)
            RUN: begin
                if (taken) begin
                    state_d       = FLUSH;
                    cnt_d         = CNT_INIT;
                    pc_redirect_d = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = RUN;
        endcase
    end

    // State registers; reset overrides every other event
    always_ff @(posedge clk) begin
        if (rst) begin
            aluin1_q      <= SEL1_PC;
            aluin2_q      <= SEL2_B;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_valid_q    <= 1'b0;
            ex_is_load_q  <= 1'b0;
            pc_redirect_q <= 1'b0;
            state_q       <= RUN;
            cnt_q         <= '0;
        end else begin
            aluin1_q      <= aluin1_d;
            aluin2_q      <= aluin2_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_valid_q    <= ex_valid_d;
            ex_is_load_q  <= ex_is_load_d;
            pc_redirect_q <= pc_redirect_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
        end
    end

    assign aluin1      = aluin1_q;
    assign aluin2      = aluin2_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_valid    = ex_valid_q;
    assign stall       = stall_c;
    assign flush       = flush_c;
    assign pc_redirect = pc_redirect_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

    // Saturating per-cycle event counters
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_c && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
        if (flush_c && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Scoreboard bench: the driver runs a behavioural model and queues the
// expected per-cycle outputs; a negedge monitor pops and compares.
module tb_execute_hazard_controller;
    localparam int FLUSH_CYCLES = 2;
    localparam int REG_AW       = 4;

    logic clk = 1'b0;
    logic rst, id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_is_load;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_src1, id_src2, ex_cond;
    logic ex_branch, ex_zero, ex_pos;
    logic [1:0] aluin1, aluin2;
    logic [3:0] ex_rd;
    logic ex_regwrite, ex_valid, stall, flush, pc_redirect;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    always #5 clk = ~clk;

    execute_hazard_controller #(.FLUSH_CYCLES(FLUSH_CYCLES), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_src1(id_src1),
        .id_src2(id_src2), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_branch(ex_branch), .ex_cond(ex_cond), .ex_zero(ex_zero), .ex_pos(ex_pos),
        .aluin1(aluin1), .aluin2(aluin2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_valid(ex_valid), .stall(stall), .flush(flush), .pc_redirect(pc_redirect)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    typedef struct packed {
        logic       rst, valid;
        logic [3:0] rs1, rs2, rd;
        logic       u1, u2;
        logic [1:0] s1, s2;
        logic       rw, ld, br;
        logic [1:0] cond;
        logic       z, p;
    } stim_t;

    typedef struct packed {
        logic [1:0] a1, a2;
        logic [3:0] rd;
        logic       rw, v, fl, pr, st;
`ifdef HAZARD_STATS_EN
        logic [15:0] sc, fc;
`endif
    } exp_t;

    exp_t sb_q[$];
    int n_vec = 0, n_err = 0;

    // Reference model: what EX should hold, and flush cycles still to run
    logic [1:0] m_a1 = 0, m_a2 = 0;
    logic [3:0] m_rd = 0;
    logic m_rw = 0, m_v = 0, m_ld = 0, m_pr = 0;
    int m_fleft = 0, m_sc = 0, m_fc = 0;
    logic last_stall = 0;

    task automatic drive_cycle(input stim_t s);
        bit ha, hb, cok, taken, infl, st;
        exp_t e;
        rst = s.rst; id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_rs1_used = s.u1; id_rs2_used = s.u2; id_src1 = s.s1; id_src2 = s.s2;
        id_rd = s.rd; id_regwrite = s.rw; id_is_load = s.ld;
        ex_branch = s.br; ex_cond = s.cond; ex_zero = s.z; ex_pos = s.p;
        ha = s.valid && s.u1 && m_v && m_rw && m_rd != 0 && m_rd == s.rs1;
        hb = s.valid && s.u2 && m_v && m_rw && m_rd != 0 && m_rd == s.rs2;
        case (s.cond)
            2'd0: cok = s.z;
            2'd1: cok = !s.z;
            2'd2: cok = s.p;
            default: cok = 1'b1;
        endcase
        taken = m_v && s.br && cok;
        infl  = m_fleft > 0;
        st    = (ha || hb) && m_ld && !infl && !taken;
        e.a1 = m_a1; e.a2 = m_a2; e.rd = m_rd; e.rw = m_rw; e.v = m_v;
        e.fl = infl; e.pr = m_pr; e.st = st;
`ifdef HAZARD_STATS_EN
        e.sc = 16'(m_sc); e.fc = 16'(m_fc);
`endif
        sb_q.push_back(e);
        last_stall = st;
        if (s.rst) begin
            m_a1 = 0; m_a2 = 0; m_rd = 0; m_rw = 0; m_v = 0; m_ld = 0; m_pr = 0;
            m_fleft = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (st && m_sc < 65535) m_sc++;
            if (infl && m_fc < 65535) m_fc++;
            m_pr = taken && !infl;
            if (taken && !infl) m_fleft = FLUSH_CYCLES;
            else if (infl)      m_fleft--;
            if (taken || infl || st || !s.valid) begin
                m_a1 = 0; m_a2 = 0; m_rd = 0; m_rw = 0; m_v = 0; m_ld = 0;
            end else begin
                m_a1 = (ha && !m_ld) ? 2'd2 : s.s1;
                m_a2 = (hb && !m_ld) ? 2'd3 : s.s2;
                m_rd = s.rd; m_rw = s.rw; m_v = 1'b1; m_ld = s.ld;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present an instruction, holding it in ID while decode is stalled
    task automatic drive_insn(input stim_t s);
        stim_t h;
        drive_cycle(s);
        h = s;
        h.br = 1'b0;
        for (int k = 0; k < 4 && last_stall; k++) drive_cycle(h);
    endtask

    function automatic stim_t insn(input logic [3:0] rd, rs1, rs2, input logic rw, ld);
        stim_t s = '0;
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = 1'b1; s.u2 = 1'b1;
        s.s1 = 2'd1; s.s2 = 2'd0; s.rw = rw; s.ld = ld;
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    // Monitor: outputs are presented every cycle, compare on the falling edge
    always @(negedge clk) begin
        exp_t e, g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g.a1 = aluin1; g.a2 = aluin2; g.rd = ex_rd; g.rw = ex_regwrite; g.v = ex_valid;
            g.fl = flush; g.pr = pc_redirect; g.st = stall;
`ifdef HAZARD_STATS_EN
            g.sc = stall_count; g.fc = flush_count;
`endif
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got a1=%0d a2=%0d rd=%0d rw=%b v=%b fl=%b pr=%b st=%b (%h) exp a1=%0d a2=%0d rd=%0d rw=%b v=%b fl=%b pr=%b st=%b (%h)",
                         $time, g.a1, g.a2, g.rd, g.rw, g.v, g.fl, g.pr, g.st, g,
                         e.a1, e.a2, e.rd, e.rw, e.v, e.fl, e.pr, e.st, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_src1 = 0; id_src2 = 0; id_rd = 0; id_regwrite = 0; id_is_load = 0;
        ex_branch = 0; ex_cond = 0; ex_zero = 0; ex_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        drive_cycle(nop());                 // reset values visible

        // back-to-back ALU dependency on operand A: forward, no stall
        drive_insn(insn(4'd3, 4'd1, 4'd2, 1, 0));
        drive_insn(insn(4'd4, 4'd3, 4'd5, 1, 0));
        drive_insn(nop()); drive_insn(nop());

        // load-use on operand B: one stall, bubble, then plain select
        drive_insn(insn(4'd3, 4'd1, 4'd2, 1, 1));
        drive_insn(insn(4'd4, 4'd5, 4'd3, 1, 0));
        drive_insn(nop()); drive_insn(nop());

        // taken branch (zero) then untaken branch
        for (int t = 0; t < 2; t++) begin
            drive_insn(insn(4'd0, 4'd1, 4'd2, 0, 0));
            s = insn(4'd5, 4'd6, 4'd7, 1, 0);
            s.br = 1'b1; s.cond = 2'd0; s.z = (t == 0);
            drive_insn(s);
            drive_insn(insn(4'd6, 4'd5, 4'd1, 1, 0));
            drive_insn(insn(4'd7, 4'd6, 4'd1, 1, 0));
            drive_insn(nop()); drive_insn(nop());
        end

        // load in EX + dependent in ID + taken branch: flush wins
        drive_insn(insn(4'd3, 4'd1, 4'd2, 1, 1));
        s = insn(4'd4, 4'd3, 4'd5, 1, 0);
        s.br = 1'b1; s.cond = 2'd3;
        drive_insn(s);
        repeat (3) drive_insn(nop());

        // r0 producer never forwards
        drive_insn(insn(4'd0, 4'd1, 4'd2, 1, 0));
        drive_insn(insn(4'd4, 4'd0, 4'd0, 1, 0));
        drive_insn(nop());

        // reset during the second flush cycle
        drive_insn(insn(4'd0, 4'd1, 4'd2, 0, 0));
        s = insn(4'd5, 4'd6, 4'd7, 1, 0);
        s.br = 1'b1; s.cond = 2'd3;
        drive_insn(s);
        drive_insn(insn(4'd6, 4'd1, 4'd1, 1, 0));
        s = insn(4'd7, 4'd1, 4'd1, 1, 0);
        s.rst = 1'b1;
        drive_cycle(s);
        drive_insn(nop()); drive_insn(nop());

        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            s = '0;
            s.valid = ($urandom_range(7) != 0);
            s.rs1 = 4'($urandom_range(3)); s.rs2 = 4'($urandom_range(3));
            s.rd  = 4'($urandom_range(3));
            s.u1 = 1'($urandom); s.u2 = 1'($urandom);
            s.s1 = 2'($urandom_range(1)); s.s2 = 2'($urandom_range(2));
            s.rw = 1'($urandom); s.ld = ($urandom_range(3) == 0);
            s.br = ($urandom_range(4) == 0); s.cond = 2'($urandom);
            s.z = 1'($urandom); s.p = 1'($urandom);
            s.rst = ($urandom_range(99) == 0);
            drive_insn(s);
        end

        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
